// File: rtl/dds_wave_gen.sv
// Phase-accumulator DDS: 32-bit accumulator, phase-continuous frequency switching, two-stage waveform pipeline.
// Define DDS_SINE_LUT_EN to build the quarter-wave sine table; otherwise wave_sel=0 produces the triangle.
module dds_wave_gen (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] freq_word,
  input  logic        freq_load,
  input  logic [7:0]  phase_ofs,
  input  logic [1:0]  wave_sel,
  input  logic        en,
  output logic [7:0]  sample,
  output logic        sample_valid,
  output logic        wrap,
  output logic [31:0] active_word
);

  localparam logic [31:0] DEFAULT_WORD = 32'd85899;

  logic [31:0] acc_reg;
  logic [31:0] pend_word_reg;
  logic        pend_flag_reg;
  logic [32:0] acc_sum;
  logic        carry;
  logic        apply;

  assign acc_sum = {1'b0, acc_reg} + {1'b0, active_word};
  assign carry   = en & acc_sum[32];
  // Switch on a period boundary; a stalled or zero-rate accumulator never reaches one, so switch at once.
  assign apply   = pend_flag_reg & (carry | (active_word == 32'd0) | ~en);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      acc_reg       <= 32'd0;
      wrap          <= 1'b0;
      active_word   <= DEFAULT_WORD;
      pend_word_reg <= 32'd0;
      pend_flag_reg <= 1'b0;
    end else begin
      if (en) begin
        acc_reg <= acc_sum[31:0];
      end
      wrap <= carry;
      if (apply) begin
        active_word <= pend_word_reg;
      end
      if (freq_load) begin
        pend_word_reg <= freq_word;
        pend_flag_reg <= 1'b1;
      end else if (apply) begin
        pend_flag_reg <= 1'b0;
      end
    end
  end

  logic [7:0] idx_next;
  logic [7:0] idx_reg;
  logic [1:0] sel_reg;
  logic       vld1_reg;
  logic       vld2_reg;

  assign idx_next = acc_reg[31:24] + phase_ofs;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      idx_reg  <= 8'd0;
      sel_reg  <= 2'd0;
      vld1_reg <= 1'b0;
      vld2_reg <= 1'b0;
    end else begin
      idx_reg  <= idx_next;
      sel_reg  <= wave_sel;
      vld1_reg <= en;
      vld2_reg <= vld1_reg;
    end
  end

`ifdef DDS_SINE_LUT_EN
  // First quadrant of round(127.5 + 127.5*sin(2*pi*(i+0.5)/256)); other quadrants by mirroring.
  localparam logic [7:0] SINE_TABLE [64] = '{
    8'd129, 8'd132, 8'd135, 8'd138, 8'd142, 8'd145, 8'd148, 8'd151,
    8'd154, 8'd157, 8'd160, 8'd163, 8'd166, 8'd169, 8'd172, 8'd175,
    8'd178, 8'd181, 8'd183, 8'd186, 8'd189, 8'd192, 8'd194, 8'd197,
    8'd200, 8'd202, 8'd205, 8'd207, 8'd210, 8'd212, 8'd214, 8'd217,
    8'd219, 8'd221, 8'd223, 8'd225, 8'd227, 8'd229, 8'd231, 8'd233,
    8'd234, 8'd236, 8'd238, 8'd239, 8'd241, 8'd242, 8'd243, 8'd245,
    8'd246, 8'd247, 8'd248, 8'd249, 8'd250, 8'd251, 8'd252, 8'd252,
    8'd253, 8'd253, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255, 8'd255
  };

  logic [5:0] rom_addr;
  logic [7:0] sine_q_reg;

  // The table read is registered alongside idx_reg so the sine path keeps the same latency.
  assign rom_addr = idx_next[6] ? ~idx_next[5:0] : idx_next[5:0];

  always_ff @(posedge sys_clk) begin
    sine_q_reg <= SINE_TABLE[rom_addr];
  end
`endif

  logic [7:0] wave_value;

  always_comb begin
    wave_value = idx_reg[7] ? {~idx_reg[6:0], 1'b0} : {idx_reg[6:0], 1'b0};
    case (sel_reg)
      2'd1: wave_value = idx_reg[7] ? 8'd0 : 8'd255;
      2'd3: wave_value = idx_reg;
`ifdef DDS_SINE_LUT_EN
      2'd0: wave_value = idx_reg[7] ? (8'd255 - sine_q_reg) : sine_q_reg;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sample       <= 8'd0;
      sample_valid <= 1'b0;
    end else begin
      if (vld2_reg) begin
        sample <= wave_value;
      end
      sample_valid <= vld2_reg;
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: directed scenarios plus random stimulus against a cycle-indexed reference model.
module tb_dds_wave_gen;

  localparam int NH = 4096;
  localparam logic [31:0] DEFAULT_WORD = 32'd85899;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] freq_word;
  logic        freq_load;
  logic [7:0]  phase_ofs;
  logic [1:0]  wave_sel;
  logic        en;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        wrap;
  logic [31:0] active_word;

  always #5 sys_clk = ~sys_clk;

  dds_wave_gen dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .freq_word    (freq_word),
    .freq_load    (freq_load),
    .phase_ofs    (phase_ofs),
    .wave_sel     (wave_sel),
    .en           (en),
    .sample       (sample),
    .sample_valid (sample_valid),
    .wrap         (wrap),
    .active_word  (active_word)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference state, indexed by clock edge number n.
  logic [31:0] m_acc, m_word, m_pend;
  logic        m_pflag, m_wrap, m_valid;
  logic [7:0]  m_sample;
  logic [31:0] acc_h [NH];
  logic        en_h  [NH];
  logic [7:0]  ofs_h [NH];
  logic [1:0]  sel_h [NH];
  int          n = 0;
  logic [7:0]  cap_q [$];

  function automatic logic [7:0] wave_ref(input logic [7:0] idx, input logic [1:0] sel);
    int i;
    int tri_v;
    i = int'(idx);
    tri_v = (i < 128) ? 2 * i : 2 * (255 - i);
    case (sel)
      2'd1: return (i < 128) ? 8'd255 : 8'd0;
      2'd2: return 8'(tri_v);
      2'd3: return idx;
      default: begin
`ifdef DDS_SINE_LUT_EN
        real r;
        r = 127.5 + 127.5 * $sin(2.0 * 3.141592653589793 * (real'(i) + 0.5) / 256.0);
        return 8'($rtoi(r + 0.5));
`else
        return 8'(tri_v);
`endif
      end
    endcase
  endfunction

  // Advance the model by one edge with the currently driven inputs, clock the DUT, then compare.
  task automatic step();
    longint s;
    logic carry, apply;
    logic [7:0] idx;
    if (sys_rst) begin
      m_acc = 32'd0; m_word = DEFAULT_WORD; m_pflag = 1'b0; m_wrap = 1'b0;
      m_sample = 8'd0; m_valid = 1'b0;
      en_h[n] = 1'b0;
      if (n >= 1) en_h[n-1] = 1'b0;
      acc_h[n] = 32'd0;
    end else begin
      m_valid = 1'b0;
      if (n >= 2) m_valid = en_h[n-2];
      if (m_valid) begin
        idx = acc_h[n-2][31:24] + ofs_h[n-1];
        m_sample = wave_ref(idx, sel_h[n-1]);
      end
      s = longint'(m_acc) + longint'(m_word);
      carry = en && (s >= 64'sh1_0000_0000);
      apply = m_pflag && (carry || m_word == 32'd0 || !en);
      if (en) m_acc = 32'(s);
      m_wrap = carry;
      if (apply) m_word = m_pend;
      if (freq_load) begin
        m_pend = freq_word;
        m_pflag = 1'b1;
      end else if (apply) begin
        m_pflag = 1'b0;
      end
      en_h[n] = en;
      acc_h[n] = m_acc;
    end
    ofs_h[n] = phase_ofs;
    sel_h[n] = wave_sel;
    @(posedge sys_clk);
    #1;
    check_eq("sample", {24'd0, sample}, {24'd0, m_sample});
    check_eq("sample_valid", {31'd0, sample_valid}, {31'd0, m_valid});
    check_eq("wrap", {31'd0, wrap}, {31'd0, m_wrap});
    check_eq("active_word", active_word, m_word);
    if (sample_valid) cap_q.push_back(sample);
    n++;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; freq_load = 1'b0; en = 1'b0;
    step();
    sys_rst = 1'b0;
  endtask

  task automatic load_apply(input logic [31:0] w);
    en = 1'b0; freq_load = 1'b1; freq_word = w;
    step();
    freq_load = 1'b0;
    step();
  endtask

  initial begin
    sys_rst = 1'b1; freq_word = 32'd0; freq_load = 1'b0;
    phase_ofs = 8'd0; wave_sel = 2'd0; en = 1'b0;
    m_acc = 32'd0; m_word = DEFAULT_WORD; m_pend = 32'd0; m_pflag = 1'b0;
    m_wrap = 1'b0; m_valid = 1'b0; m_sample = 8'd0;
    #2;
    do_reset();
    do_reset();
    check_eq("rst_active_word", active_word, DEFAULT_WORD);
    check_eq("rst_sample", {24'd0, sample}, 32'd0);

    // Sawtooth at quarter rate: wrap every 4th cycle.
    wave_sel = 2'd3; phase_ofs = 8'd0;
    load_apply(32'h4000_0000);
    check_eq("load_applied", active_word, 32'h4000_0000);
    cap_q.delete();
    en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    for (int i = 0; i < 4; i++) check_eq("saw_seq", {24'd0, cap_q[i]}, 32'((64 * (i + 1)) % 256));

    // Mid-period reload to an eighth rate, applied at the next carry-out.
    freq_load = 1'b1; freq_word = 32'h2000_0000;
    step();
    check_eq("reload_deferred", active_word, 32'h4000_0000);
    freq_load = 1'b0;
    for (int i = 0; i < 20; i++) step();

    // Square with half-period phase offset.
    do_reset();
    wave_sel = 2'd1; phase_ofs = 8'h80;
    load_apply(32'h4000_0000);
    cap_q.delete();
    en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check_eq("square_0", {24'd0, cap_q[0]}, 32'd0);
    check_eq("square_1", {24'd0, cap_q[1]}, 32'd255);
    check_eq("square_2", {24'd0, cap_q[2]}, 32'd255);
    check_eq("square_3", {24'd0, cap_q[3]}, 32'd0);

    // Enable toggling 1,1,0,0,1.
    en = 1'b1; step(); step();
    en = 1'b0; step(); step();
    en = 1'b1; step();
    en = 1'b0; step(); step(); step();

    // Walk every table index once.
    do_reset();
    wave_sel = 2'd0; phase_ofs = 8'd0;
    load_apply(32'h0100_0000);
    cap_q.delete();
    en = 1'b1;
    for (int i = 0; i < 260; i++) step();
`ifdef DDS_SINE_LUT_EN
    check_eq("sine_idx0", {24'd0, cap_q[255]}, 32'd129);
    check_eq("sine_idx63", {24'd0, cap_q[62]}, 32'd255);
    check_eq("sine_idx128", {24'd0, cap_q[127]}, 32'd126);
    check_eq("sine_idx191", {24'd0, cap_q[190]}, 32'd0);
`else
    check_eq("tri_idx0", {24'd0, cap_q[255]}, 32'd0);
    check_eq("tri_idx63", {24'd0, cap_q[62]}, 32'd126);
    check_eq("tri_idx128", {24'd0, cap_q[127]}, 32'd254);
    check_eq("tri_idx191", {24'd0, cap_q[190]}, 32'd128);
`endif

    // Reset mid-run together with a load: the load is discarded.
    sys_rst = 1'b1; freq_load = 1'b1; freq_word = 32'h1234_5678; en = 1'b1;
    step();
    check_eq("rst_load_word", active_word, DEFAULT_WORD);
    check_eq("rst_load_valid", {31'd0, sample_valid}, 32'd0);
    check_eq("rst_load_wrap", {31'd0, wrap}, 32'd0);
    sys_rst = 1'b0; freq_load = 1'b0; en = 1'b0;
    step(); step();
    check_eq("rst_pending_cleared", active_word, DEFAULT_WORD);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      sys_rst = ($urandom_range(0, 149) == 0);
      en = ($urandom_range(0, 9) < 8);
      freq_load = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: freq_word = 32'd0;
        1: freq_word = $urandom_range(1, 255);
        2: freq_word = $urandom | 32'h1000_0000;
        default: freq_word = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) phase_ofs = 8'($urandom);
      if ($urandom_range(0, 9) == 0) wave_sel = 2'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
